// File: rtl/hs_ifr_misc_typedefs_pkg.sv
// Shared small typedefs for the hs_ifr/hs_unit blocks.
package hs_ifr_misc_typedefs_pkg;

   // Which transition of a monitored line counts as an event.
   typedef enum logic [1:0] {
      EDGE_POSEDGE = 2'd0,
      EDGE_NEGEDGE = 2'd1,
      EDGE_BOTH    = 2'd2
   } edge_e;

endpackage : hs_ifr_misc_typedefs_pkg

// File: rtl/hs_unit_rr_sel.sv
// Combinational round-robin selector: searches ptr+1, ptr+2, ... modulo
// N_CH and grants the first requesting index.
module hs_unit_rr_sel #(
   parameter  int unsigned N_CH = 4,
   localparam int unsigned IDW  = $clog2(N_CH)
)(
   input  logic [N_CH-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic            gnt_vld,
   output logic [IDW-1:0]  gnt_id
);

   // First set request after ptr wins; ptr itself is checked last.
   always_comb begin
      int idx;
      idx     = 0;
      gnt_vld = 1'b0;
      gnt_id  = '0;
      for (int k = 1; k <= int'(N_CH); k++) begin
         idx = (int'(ptr) + k) % int'(N_CH);
         if (!gnt_vld && req[idx]) begin
            gnt_vld = 1'b1;
            gnt_id  = idx[IDW-1:0];
         end
      end
   end

endmodule : hs_unit_rr_sel

// File: rtl/hs_unit_sedge_det.sv
// Single-line synchronous edge detector with enable qualification.
// The delay register resets to 0, so a line already high when reset is
// released is reported as a rising edge on the first clock.
module hs_unit_sedge_det
   import hs_ifr_misc_typedefs_pkg::*;
#(
   parameter edge_e EDGE = EDGE_POSEDGE
)(
   input  logic clk,
   input  logic aresetn,
   input  logic sig,
   input  logic en,
   output logic edge_det
);

   logic dly;
   logic raw;

   // Previous-cycle copy of the line; it tracks even while disabled so that
   // re-enabling a channel never produces a stale edge.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         dly <= 1'b0;
      end else begin
         dly <= sig;
      end
   end

   // Edge selection, gated by the channel enable.
   always_comb begin
      raw = 1'b0;
      case (EDGE)
         EDGE_POSEDGE: raw = sig & ~dly;
         EDGE_NEGEDGE: raw = ~sig & dly;
         EDGE_BOTH:    raw = sig ^ dly;
         default:      raw = 1'b0;
      endcase
      edge_det = raw & en;
   end

endmodule : hs_unit_sedge_det

// File: rtl/hs_unit_edge_evt_arb.sv
// Multi-channel edge-event collector with round-robin serialisation onto a
// valid/ready event port. Holds the pending and overflow flags, the output
// register and the round-robin pointer.
module hs_unit_edge_evt_arb
   import hs_ifr_misc_typedefs_pkg::*;
#(
   parameter  int unsigned N_CH = 4,
   parameter  edge_e       EDGE = EDGE_POSEDGE,
   localparam int unsigned IDW  = $clog2(N_CH)
)(
   input  logic            clk,
   input  logic            aresetn,
   input  logic [N_CH-1:0] signal_in,
   input  logic [N_CH-1:0] ch_en,
   output logic            evt_valid,
   input  logic            evt_ready,
   output logic [IDW-1:0]  evt_id,
   output logic [N_CH-1:0] pend,
   output logic [N_CH-1:0] ovf,
   input  logic [N_CH-1:0] ovf_clr
);

   logic [N_CH-1:0] edge_det;
   logic [N_CH-1:0] ld_ch;
   logic [N_CH-1:0] pend_nxt;
   logic [N_CH-1:0] ovf_nxt;
   logic [IDW-1:0]  rr_ptr;
   logic            out_free;
   logic            gnt_vld;
   logic [IDW-1:0]  gnt_id;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      hs_unit_sedge_det #(
         .EDGE (EDGE)
      ) u_det (
         .clk      (clk),
         .aresetn  (aresetn),
         .sig      (signal_in[i]),
         .en       (ch_en[i]),
         .edge_det (edge_det[i])
      );
   end

   hs_unit_rr_sel #(
      .N_CH (N_CH)
   ) u_rr_sel (
      .req     (pend),
      .ptr     (rr_ptr),
      .gnt_vld (gnt_vld),
      .gnt_id  (gnt_id)
   );

   // Output register may take a new value when empty or being drained.
   assign out_free = !evt_valid || evt_ready;

   // One-hot mask of the channel moved into the output register this cycle.
   always_comb begin
      ld_ch = '0;
      if (out_free && gnt_vld) begin
         ld_ch[gnt_id] = 1'b1;
      end
   end

   // Next pending/overflow state; a new edge beats the load clear, and a new
   // overflow beats the software clear.
   always_comb begin
      pend_nxt = pend;
      ovf_nxt  = ovf;
      for (int i = 0; i < int'(N_CH); i++) begin
         if (!ch_en[i]) begin
            pend_nxt[i] = 1'b0;
         end else if (edge_det[i]) begin
            pend_nxt[i] = 1'b1;
         end else if (ld_ch[i]) begin
            pend_nxt[i] = 1'b0;
         end

         if (edge_det[i] && pend[i] && !ld_ch[i]) begin
            ovf_nxt[i] = 1'b1;
         end else if (ovf_clr[i]) begin
            ovf_nxt[i] = 1'b0;
         end
      end
   end

   // Flag registers.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         pend <= '0;
         ovf  <= '0;
      end else begin
         pend <= pend_nxt;
         ovf  <= ovf_nxt;
      end
   end

   // Output register and round-robin pointer; ptr starts at the last channel
   // so channel 0 has first priority out of reset.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         evt_valid <= 1'b0;
         evt_id    <= '0;
         rr_ptr    <= IDW'(N_CH - 1);
      end else if (out_free) begin
         if (gnt_vld) begin
            evt_valid <= 1'b1;
            evt_id    <= gnt_id;
            rr_ptr    <= gnt_id;
         end else begin
            evt_valid <= 1'b0;
         end
      end
   end

endmodule : hs_unit_edge_evt_arb

// File: tb/tb_hs_unit_edge_evt_arb.sv
// Directed bench for hs_unit_edge_evt_arb: a rising-edge instance carries
// most of the sequence, a falling-edge instance covers the reset-release case.
module tb_hs_unit_edge_evt_arb;
   import hs_ifr_misc_typedefs_pkg::*;

   logic       clk = 1'b0;
   logic       aresetn;
   logic [3:0] sig, sig_n, en, ovf_clr;
   logic       ready;

   logic       valid, valid_n;
   logic [1:0] id, id_n;
   logic [3:0] pend, pend_n, ovf, ovf_n;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   hs_unit_edge_evt_arb #(.N_CH(4), .EDGE(EDGE_POSEDGE)) dut (
      .clk       (clk),
      .aresetn   (aresetn),
      .signal_in (sig),
      .ch_en     (en),
      .evt_valid (valid),
      .evt_ready (ready),
      .evt_id    (id),
      .pend      (pend),
      .ovf       (ovf),
      .ovf_clr   (ovf_clr)
   );

   hs_unit_edge_evt_arb #(.N_CH(4), .EDGE(EDGE_NEGEDGE)) dut_n (
      .clk       (clk),
      .aresetn   (aresetn),
      .signal_in (sig_n),
      .ch_en     (en),
      .evt_valid (valid_n),
      .evt_ready (ready),
      .evt_id    (id_n),
      .pend      (pend_n),
      .ovf       (ovf_n),
      .ovf_clr   (ovf_clr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      aresetn = 1'b0; sig = '0; sig_n = '0; en = 4'hF; ready = 1'b1; ovf_clr = '0;
      #2;
      chk("rst_valid", 32'(valid), 0);
      chk("rst_id",    32'(id),    0);
      chk("rst_pend",  32'(pend),  0);
      chk("rst_ovf",   32'(ovf),   0);
      chk("rst_valid_n", 32'(valid_n), 0);
      tick(); tick();
      aresetn = 1'b1;
      tick();
      chk("idle_pend",  32'(pend),  0);
      chk("idle_valid", 32'(valid), 0);

      // three channels rise together, ptr=3 -> 0,1,3
      sig = 4'b1011;
      tick(); chk("t2_pend", 32'(pend), 32'b1011); chk("t2_v0", 32'(valid), 0);
      tick(); chk("t2_a_v", 32'(valid), 1); chk("t2_a_id", 32'(id), 0); chk("t2_a_p", 32'(pend), 32'b1010);
      tick(); chk("t2_b_id", 32'(id), 1); chk("t2_b_p", 32'(pend), 32'b1000);
      tick(); chk("t2_c_id", 32'(id), 3); chk("t2_c_p", 32'(pend), 0);
      tick(); chk("t2_end_v", 32'(valid), 0);
      sig = 4'b0000; tick();
      sig = 4'b1001;
      tick(); chk("t2b_pend", 32'(pend), 32'b1001);
      tick(); chk("t2b_a_id", 32'(id), 0); chk("t2b_a_v", 32'(valid), 1);
      tick(); chk("t2b_b_id", 32'(id), 3);
      tick(); chk("t2b_end_v", 32'(valid), 0);

      // single channel latency
      sig = 4'b1101;
      tick(); chk("t1_pend", 32'(pend), 32'b0100); chk("t1_v0", 32'(valid), 0);
      tick(); chk("t1_v1", 32'(valid), 1); chk("t1_id", 32'(id), 2); chk("t1_p0", 32'(pend), 0);
      tick(); chk("t1_v2", 32'(valid), 0);

      // backpressure hold and overflow
      ready = 1'b0;
      sig = 4'b1111;
      tick(); chk("t3_pend", 32'(pend), 32'b0010);
      tick(); chk("t3_v", 32'(valid), 1); chk("t3_id", 32'(id), 1);
      for (int c = 0; c < 10; c++) begin
         tick();
         chk("t3_hold_v",  32'(valid), 1);
         chk("t3_hold_id", 32'(id),    1);
      end
      sig = 4'b1101; tick();
      sig = 4'b1111; tick();
      chk("t3_2nd_pend", 32'(pend), 32'b0010); chk("t3_2nd_ovf", 32'(ovf), 0);
      sig = 4'b1101; tick();
      sig = 4'b1111; tick();
      chk("t3_3rd_ovf", 32'(ovf), 32'b0010); chk("t3_3rd_pend", 32'(pend), 32'b0010);
      chk("t3_3rd_id", 32'(id), 1);
      ready = 1'b1;
      tick(); chk("t3_rel_v", 32'(valid), 1); chk("t3_rel_id", 32'(id), 1); chk("t3_rel_p", 32'(pend), 0);
      tick(); chk("t3_drain_v", 32'(valid), 0); chk("t3_ovf_keep", 32'(ovf), 32'b0010);

      // overflow set beats simultaneous clear
      ready = 1'b0;
      sig = 4'b1101; tick();
      sig = 4'b1111; tick(); chk("t5_pend", 32'(pend), 32'b0010);
      tick(); chk("t5_v", 32'(valid), 1);
      sig = 4'b1101; tick();
      sig = 4'b1111; tick(); chk("t5_pend2", 32'(pend), 32'b0010);
      sig = 4'b1101; tick();
      sig = 4'b1111; ovf_clr = 4'b0010;
      tick(); chk("t5_setwins", 32'(ovf), 32'b0010);
      tick(); chk("t5_clr", 32'(ovf), 0);
      ovf_clr = '0;
      ready = 1'b1;
      tick(); chk("t5_rel_id", 32'(id), 1); chk("t5_rel_v", 32'(valid), 1);
      tick(); chk("t5_drain_v", 32'(valid), 0);

      // channel disable clears pending, ignores edges, keeps presented event
      ready = 1'b0;
      sig = 4'b1100; tick();
      sig = 4'b1001; tick(); chk("t4_pend0", 32'(pend), 32'b0001);
      tick(); chk("t4_v", 32'(valid), 1); chk("t4_id", 32'(id), 0);
      sig = 4'b1101; tick(); chk("t4_pend2", 32'(pend), 32'b0100);
      en = 4'b1010;
      tick(); chk("t4_dis_pend", 32'(pend), 0); chk("t4_keep_v", 32'(valid), 1); chk("t4_keep_id", 32'(id), 0);
      sig = 4'b1001; tick();
      sig = 4'b1101; tick();
      sig = 4'b1001; tick();
      sig = 4'b1101; tick();
      chk("t4_tog_pend", 32'(pend), 0); chk("t4_tog_ovf", 32'(ovf), 0);
      ready = 1'b1;
      tick(); chk("t4_drain_v", 32'(valid), 0);
      en = 4'hF;
      tick(); chk("t4_reen_pend", 32'(pend), 0);

      // asynchronous reset mid-transfer
      ready = 1'b0;
      sig = 4'b0101; tick();
      sig = 4'b1101; tick(); chk("t6_pend3", 32'(pend), 32'b1000);
      tick(); chk("t6_v", 32'(valid), 1); chk("t6_id", 32'(id), 3);
      aresetn = 1'b0;
      #1;
      chk("t6_rst_v",    32'(valid), 0);
      chk("t6_rst_id",   32'(id),    0);
      chk("t6_rst_pend", 32'(pend),  0);
      chk("t6_rst_ovf",  32'(ovf),   0);
      sig = 4'b0010; sig_n = 4'b0010; ready = 1'b1;
      tick();
      aresetn = 1'b1;
      tick(); chk("t6_hi_pend", 32'(pend), 32'b0010); chk("t6_n_pend", 32'(pend_n), 0);
      tick(); chk("t6_hi_v", 32'(valid), 1); chk("t6_hi_id", 32'(id), 1); chk("t6_n_v", 32'(valid_n), 0);
      sig_n = 4'b0000;
      tick(); chk("t6_n_fall_pend", 32'(pend_n), 32'b0010); chk("t6_after_v", 32'(valid), 0);
      tick(); chk("t6_n_fall_v", 32'(valid_n), 1); chk("t6_n_fall_id", 32'(id_n), 1);
      tick(); chk("t6_n_drain_v", 32'(valid_n), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_hs_unit_edge_evt_arb
